// File: rtl/core_test_sequencer_if.sv
// core_test_sequencer_if: control and status bundle between a test controller and the sequencer.
// Ports (controller view, modport master):
//   start      out  one-cycle pulse that begins a sequence
//   abort      out  level that forces the sequencer back to IDLE
//   test_done  out  core reports that the current test has finished
//   test_pass  out  qualifier of test_done: 1 = pass, 0 = fail
//   core_rst_n, test_idx, busy, all_done, all_pass,
//   pass_count, fail_count, timeout_count, fail_mask  in  sequencer status
// The sequencer side connects through modport slave, with the directions reversed.
interface core_test_sequencer_if #(
  parameter int NUM_TESTS = 6,
  parameter int CNT_W = 9,
  parameter int IDX_W = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
);
  logic start, abort, test_done, test_pass;
  logic core_rst_n, busy, all_done, all_pass;
  logic [IDX_W-1:0] test_idx;
  logic [CNT_W-1:0] pass_count, fail_count, timeout_count;
  logic [NUM_TESTS-1:0] fail_mask;
  modport master (
    output start, abort, test_done, test_pass,
    input core_rst_n, test_idx, busy, all_done, all_pass, pass_count, fail_count, timeout_count, fail_mask
  );
  modport slave (
    input start, abort, test_done, test_pass,
    output core_rst_n, test_idx, busy, all_done, all_pass, pass_count, fail_count, timeout_count, fail_mask
  );
endinterface

// File: rtl/core_test_sequencer.sv
// core_test_sequencer: steps a core under test through NUM_TESTS reset/run windows,
// forcing a fail on hung tests and tallying the results.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    core_test_sequencer_if.slave
//          inputs:  start, abort, test_done, test_pass
//          outputs: core_rst_n, test_idx, busy, all_done, all_pass,
//                   pass_count, fail_count, timeout_count, fail_mask
module core_test_sequencer #(
  parameter int NUM_TESTS = 6,
  parameter int RST_CYCLES = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int STOP_ON_FAIL = 0,
  parameter int CNT_W = 9,
  parameter int IDX_W = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
  input logic clk,
  input logic rst_n,
  core_test_sequencer_if.slave bus
);
  localparam int CYC_MAX = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
  localparam int CYC_W = $clog2(CYC_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  typedef enum logic [1:0] {IDLE, RESET, RUN, FINISH} state_t;
  state_t state, state_n;
  logic [CYC_W-1:0] cyc, cyc_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] pass_c, pass_n, fail_c, fail_n, tmo_c, tmo_n;
  logic [NUM_TESTS-1:0] mask, mask_n;
  logic crst_q, busy_q, done_q, apass_q;
  logic rst_end, run_end, failed, stop;
  assign rst_end = cyc == CYC_W'(RST_CYCLES - 1);
  // a done seen on the final timeout clock ends the run as an ordinary result
  assign run_end = bus.test_done || cyc == CYC_W'(TIMEOUT_CYCLES - 1);
  assign failed = !(bus.test_done && bus.test_pass);
  assign stop = idx == IDX_W'(NUM_TESTS - 1) || (STOP_ON_FAIL != 0 && failed);
  always_comb begin
    state_n = state;
    cyc_n = cyc;
    idx_n = idx;
    pass_n = pass_c;
    fail_n = fail_c;
    tmo_n = tmo_c;
    mask_n = mask;
    if (bus.abort) state_n = IDLE;
    else if ((state == IDLE || state == FINISH) && bus.start) begin
      state_n = RESET;
      cyc_n = '0;
      idx_n = '0;
      pass_n = '0;
      fail_n = '0;
      tmo_n = '0;
      mask_n = '0;
    end else if (state == RESET) begin
      state_n = rst_end ? RUN : RESET;
      cyc_n = rst_end ? '0 : cyc + 1'b1;
    end else if (state == RUN && run_end) begin
      state_n = stop ? FINISH : RESET;
      cyc_n = '0;
      idx_n = stop ? idx : idx + 1'b1;
      pass_n = (!failed && pass_c != CNT_SAT) ? pass_c + 1'b1 : pass_c;
      fail_n = (failed && fail_c != CNT_SAT) ? fail_c + 1'b1 : fail_c;
      tmo_n = (!bus.test_done && tmo_c != CNT_SAT) ? tmo_c + 1'b1 : tmo_c;
      mask_n = failed ? mask | (NUM_TESTS'(1) << idx) : mask;
    end else if (state == RUN) cyc_n = cyc + 1'b1;
  end
  // status flags are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cyc <= '0;
      idx <= '0;
      pass_c <= '0;
      fail_c <= '0;
      tmo_c <= '0;
      mask <= '0;
      crst_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      apass_q <= 1'b0;
    end else begin
      state <= state_n;
      cyc <= cyc_n;
      idx <= idx_n;
      pass_c <= pass_n;
      fail_c <= fail_n;
      tmo_c <= tmo_n;
      mask <= mask_n;
      crst_q <= state_n == RUN;
      busy_q <= state_n == RESET || state_n == RUN;
      done_q <= state_n == FINISH;
      apass_q <= state_n == FINISH && fail_n == '0 && int'(pass_n) == NUM_TESTS;
    end
  end
  assign bus.core_rst_n = crst_q;
  assign bus.busy = busy_q;
  assign bus.all_done = done_q;
  assign bus.all_pass = apass_q;
  assign bus.test_idx = idx;
  assign bus.pass_count = pass_c;
  assign bus.fail_count = fail_c;
  assign bus.timeout_count = tmo_c;
  assign bus.fail_mask = mask;
endmodule

// File: doc/core_test_sequencer.md
CORE_TEST_SEQUENCER -- requirements
Module: core_test_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NUM_TESTS, 6, number of test programs run per sequence (1..256).
- RST_CYCLES, 8, clocks core_rst_n is held low before each test (>=1).
- TIMEOUT_CYCLES, 1024, maximum RUN clocks per test before forced fail (>=2).
- STOP_ON_FAIL, 0, 1 = end sequence at first failing test; 0 = run all tests.
- CNT_W, 9, width of pass/fail counters.
- IDX_W, max(1, clog2(NUM_TESTS)), width of test_idx.

REQ-002 Ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle pulse; begins a sequence from IDLE or FINISH.
- abort  in  1  level; forces return to IDLE.
- test_done  in  1  core reports current test finished (sampled only in RUN).
- test_pass  in  1  qualifier of test_done: 1 = pass, 0 = fail.
- core_rst_n  out  1  active-low reset to core under test.
- test_idx  out  IDX_W  index of current/last test program.
- busy  out  1  high in RESET and RUN.
- all_done  out  1  high in FINISH.
- all_pass  out  1  high in FINISH when every test ran and passed.
- pass_count  out  CNT_W  tests passed this sequence.
- fail_count  out  CNT_W  tests failed (incl. timeouts) this sequence.
- timeout_count  out  CNT_W  tests failed by timeout.
- fail_mask  out  NUM_TESTS  bit i set when test i failed.

Function
REQ-003 States: IDLE, RESET, RUN, FINISH; registered state, registered outputs.
REQ-004 core_rst_n SHALL be 0 in IDLE, RESET, FINISH; 1 only in RUN.
REQ-005 start in IDLE/FINISH: clear all counters and fail_mask, test_idx=0, enter RESET next cycle; start in RESET/RUN ignored.
REQ-006 RESET: hold exactly RST_CYCLES clocks, then RUN with cycle counter cleared.
REQ-007 RUN: test_done sampled high -> result = test_pass; test_done ignored outside RUN.
REQ-008 RUN: no test_done after TIMEOUT_CYCLES clocks -> result = fail, timeout_count increments.
REQ-009 test_done high on the final timeout clock: done wins, no timeout recorded.
REQ-010 Result SHALL update counters/fail_mask on the same edge RUN exits (visible 1 cycle after test_done); core_rst_n low that same cycle.
REQ-011 RUN exit: last test (test_idx==NUM_TESTS-1) or (STOP_ON_FAIL and fail) -> FINISH; else test_idx+1 -> RESET.
REQ-012 Counters saturate at 2^CNT_W-1; no wrap.
REQ-013 all_pass = 1 in FINISH iff fail_count==0 and pass_count==NUM_TESTS.
REQ-014 FINISH holds all results stable until start or abort.
REQ-015 abort (any state) -> IDLE next cycle, core_rst_n=0, counters and fail_mask retained; abort has priority over start and test_done.

Reset
REQ-016 rst_n low: immediately state=IDLE, core_rst_n=0, test_idx=0, busy=0, all_done=0, all_pass=0, all counters=0, fail_mask=0.
REQ-017 rst_n low mid-RUN: sequence discarded; no result recorded; start required after release.

Verification (NUM_TESTS=4, RST_CYCLES=3, TIMEOUT_CYCLES=20, STOP_ON_FAIL=0)
REQ-018 start, each test pulses test_done with test_pass=1 after 5 RUN clocks -> core_rst_n low 3 clocks before each test, all_done, pass_count=4, fail_mask=0000, all_pass=1.
REQ-019 test 2 pass=0, others pass -> pass_count=3, fail_count=1, fail_mask=0100, all_pass=0, test_idx=3 in FINISH.
REQ-020 test 1 never asserts test_done -> leaves RUN after 20 clocks, timeout_count=1, fail_mask=0010; test_done on exactly 20th clock instead -> pass, timeout_count=0.
REQ-021 STOP_ON_FAIL=1, test 1 fails -> FINISH with test_idx=1, pass_count=1, fail_count=1, tests 2-3 never run.
REQ-022 abort mid-RUN of test 2 -> IDLE next cycle, core_rst_n=0, pass_count=2 retained; rst_n pulse mid-RESET -> all outputs to reset values asynchronously; start in RUN ignored.
